// File: rtl/plugin_scheduler.sv
// Round-robin arbiter sharing one plugin_adder between NUM_REQ requesters, with
// per-requester valid/ready request and response channels and a WAIT-state timeout.
module plugin_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*32-1:0]  req_opa_i,
    input  logic [NUM_REQ*32-1:0]  req_opb_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    input  logic [NUM_REQ-1:0]     rsp_ready_i,
    output logic [31:0]            rsp_data_o,
    output logic                   rsp_error_o,
    output logic                   plugin_start_o,
    output logic [31:0]            plugin_opa_o,
    output logic [31:0]            plugin_opb_o,
    input  logic [31:0]            plugin_result_i,
    input  logic                   plugin_busy_i,
    input  logic                   plugin_done_i,
    output logic [2:0]             grant_id_o,
    output logic                   idle_o,
    output logic [31:0]            op_count_o
);

    localparam int unsigned IdxW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state;
    logic [2:0]      last_grant;
    logic [15:0]     timer;
    logic            any_req;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] scan_idx;
    logic [IdxW-1:0] grant_idx;
    logic [31:0]     win_opa;
    logic [31:0]     win_opb;

    assign grant_idx = grant_id_o[IdxW-1:0];

    // First valid requester after last_grant, wrapping modulo NUM_REQ.
    always_comb begin
        any_req  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = IdxW'((32'(last_grant) + i) % NUM_REQ);
            if (!any_req && req_valid_i[scan_idx]) begin
                any_req = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        win_opa = '0;
        win_opb = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (win_idx == IdxW'(j)) begin
                win_opa = req_opa_i[32*j +: 32];
                win_opb = req_opb_i[32*j +: 32];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (state == StIdle && any_req) begin
            req_ready_o[win_idx] = 1'b1;
        end
        if (state == StResp) begin
            rsp_valid_o[grant_idx] = 1'b1;
        end
    end

    // Start is withheld while the adder is still busy; it fires on the first free cycle.
    assign plugin_start_o = (state == StIssue) && !plugin_busy_i;
    assign idle_o         = (state == StIdle);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= StIdle;
            last_grant   <= 3'(NUM_REQ - 1);
            timer        <= '0;
            op_count_o   <= '0;
            grant_id_o   <= '0;
            plugin_opa_o <= '0;
            plugin_opb_o <= '0;
            rsp_data_o   <= '0;
            rsp_error_o  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        plugin_opa_o <= win_opa;
                        plugin_opb_o <= win_opb;
                        grant_id_o   <= 3'(win_idx);
                        state        <= StIssue;
                    end
                end
                StIssue: begin
                    if (!plugin_busy_i) begin
                        timer <= '0;
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (plugin_done_i) begin
                        rsp_data_o  <= plugin_result_i;
                        rsp_error_o <= 1'b0;
                        state       <= StResp;
                    end else if (timer == TimeoutLast) begin
                        rsp_data_o  <= '0;
                        rsp_error_o <= 1'b1;
                        state       <= StResp;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready_i[grant_idx]) begin
                        last_grant <= grant_id_o;
                        op_count_o <= op_count_o + 32'd1;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/plugin_scheduler.md
Name: plugin_scheduler

Overview:
Round-robin scheduler that shares the single plugin_adder datapath between NUM_REQ independent requesters, such as the core's memory-mapped port and accelerator/DMA masters.
- Each requester submits an operand pair over a valid/ready request channel.
- It receives the result, or a timeout error, on its own valid/ready response channel.
- The block drives plugin_adder's start/operand inputs and monitors its busy/done outputs; it sits between the requesters and the plugin_adder instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 255, max cycles spent in WAIT before the op is aborted with error (1..65535)

Ports:
clk  input  1  clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
req_valid_i  input  NUM_REQ  per-requester request valid
req_ready_o  output  NUM_REQ  per-requester request accept (one-hot or zero)
req_opa_i  input  NUM_REQ*32  operand A, requester k at bits [32k+31:32k]
req_opb_i  input  NUM_REQ*32  operand B, same packing
rsp_valid_o  output  NUM_REQ  per-requester response valid (one-hot or zero)
rsp_ready_i  input  NUM_REQ  per-requester response accept
rsp_data_o  output  32  result, shared by all requesters
rsp_error_o  output  1  1 = timeout, rsp_data_o = 0
plugin_start_o  output  1  one-cycle start pulse to plugin_adder
plugin_opa_o  output  32  operand A to plugin_adder
plugin_opb_o  output  32  operand B to plugin_adder
plugin_result_i  input  32  plugin_adder result
plugin_busy_i  input  1  plugin_adder busy
plugin_done_i  input  1  plugin_adder done
grant_id_o  output  3  index of requester currently owning the datapath
idle_o  output  1  1 when FSM is in IDLE
op_count_o  output  32  completed-op counter (done or timeout), wraps 0xFFFFFFFF->0

Behaviour:
- Reset (reset_n low at clk edge):
  - FSM = IDLE; all outputs 0 except idle_o = 1.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - timer = 0, op_count_o = 0.
  - Reset mid-operation abandons the op; no response is issued. plugin_adder is reset from the same reset_n.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i bit is set, the winner is the first set bit searching last_grant+1, last_grant+2, ... (mod NUM_REQ).
  - req_ready_o[winner] = 1 combinationally in that cycle only; all other ready bits are 0.
  - On the edge: latch opa/opb into plugin_opa_o/plugin_opb_o and winner into grant_id_o; go to ISSUE.
  - req_ready_o is 0 in all other states.
- ISSUE:
  - plugin_start_o = 1 for exactly this cycle.
  - If plugin_busy_i = 1 here, hold in ISSUE with start deasserted until busy = 0, then re-pulse start.
  - Next state is WAIT; timer cleared to 0.
- WAIT:
  - plugin_opa_o/plugin_opb_o are held stable from ISSUE through WAIT exit.
  - timer increments each cycle.
  - plugin_done_i = 1: latch rsp_data_o = plugin_result_i, rsp_error_o = 0; go to RESP.
  - Else if timer == TIMEOUT_CYCLES-1: rsp_data_o = 0, rsp_error_o = 1; go to RESP.
  - done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid_o[grant_id_o] = 1; data and error are held until rsp_ready_i[grant_id_o] = 1.
  - On the handshake edge: last_grant = grant_id_o, op_count_o += 1, go to IDLE.
  - rsp_ready_i of other requesters is ignored.
- plugin_done_i outside WAIT is ignored (spurious).
- Throughput: minimum 4 cycles per op plus adder latency. A requester holding req_valid_i continuously is granted at most once per NUM_REQ ops while others are waiting.
- Requesters must hold req_valid_i and operands stable until ready; behaviour on withdrawal is undefined.

Test Plan:
- Single request: req 2 sends 0x00000005 + 0x0000000A, model done after 3 cycles -> rsp_valid_o = 0b0100, rsp_data_o = 0x0000000F, error 0, op_count_o = 1.
- Full contention: all 4 valid continuously from reset -> grant order 0,1,2,3,0. Each result equals its own opa+opb, including 0xFFFFFFFF + 1 = 0x00000000 wrap.
- Response backpressure: rsp_ready_i held 0 for 10 cycles -> rsp_valid_o, rsp_data_o and grant_id_o stable; req_ready_o stays 0; no new start pulse.
- Timeout: TIMEOUT_CYCLES = 8, model never asserts done -> RESP after exactly 8 WAIT cycles with rsp_error_o = 1, rsp_data_o = 0. A done arriving on the timeout cycle -> error 0 with the correct result.
- Busy at issue: plugin_busy_i = 1 for 5 cycles on ISSUE entry -> start asserted only on the first cycle busy = 0.
- Reset mid-op: reset_n low during WAIT -> next cycle idle_o = 1, all rsp_valid_o = 0, op_count_o = 0, next grant goes to requester 0.
